// File: rtl/usb4_tx_pkg.sv
// Shared definitions for the USB4 transmit-side transport byte path.
package usb4_tx_pkg;

  localparam int TX_SLOT_CYCLES_DEFAULT = 4;
  localparam int TX_FIFO_DEPTH_DEFAULT  = 16;

  typedef enum logic {
    TX_IDLE   = 1'b0,
    TX_ACTIVE = 1'b1
  } tx_state_e;

endpackage

// File: rtl/tx_byte_fifo.sv
// Synchronous byte FIFO with explicit occupancy count; pushes are refused
// whenever it is full at the edge, even if a pop happens on that same edge.
module tx_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/transport_byte_tx.sv
// Byte pacer toward the USB4 logical layer: buffers producer bytes and, while
// the link is in CL0, launches one byte every SLOT_CYCLES clocks.
//
// state     | meaning
// TX_IDLE   | link not in CL0; outputs held at 0, FIFO still accepts pushes
// TX_ACTIVE | link in CL0; slot counter running, one launch per slot
module transport_byte_tx
  import usb4_tx_pkg::*;
#(
  parameter int DEPTH       = TX_FIFO_DEPTH_DEFAULT,
  parameter int SLOT_CYCLES = TX_SLOT_CYCLES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       cl0_s,
  output logic [7:0]                 transport_layer_data_in,
  output logic                       transport_data_flag,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       underrun
);

  localparam int SW = $clog2(SLOT_CYCLES);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);

  tx_state_e state;
  tx_state_e state_nxt;

  logic [SW-1:0] slot_cnt;
  logic          launch;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;

  tx_byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s_valid),
    .din   (s_data),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign s_ready = !fifo_full;

  always_ff @(posedge clk) begin
    if (reset) state <= TX_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      TX_IDLE: begin
        if (cl0_s) begin
          state_nxt = TX_ACTIVE;
          launch    = 1'b1;
        end
      end
      TX_ACTIVE: begin
        if (!cl0_s) state_nxt = TX_IDLE;
        else        launch    = (slot_cnt == SLOT_LAST);
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  assign fifo_pop = launch && !fifo_empty;

  // A launch always resets the slot phase, so entry and wrap share one path.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt                <= '0;
      transport_layer_data_in <= '0;
      transport_data_flag     <= 1'b0;
      underrun                <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (state_nxt == TX_IDLE) begin
        slot_cnt                <= '0;
        transport_layer_data_in <= '0;
        transport_data_flag     <= 1'b0;
      end else if (launch) begin
        slot_cnt                <= '0;
        transport_layer_data_in <= fifo_empty ? 8'h00 : fifo_head;
        transport_data_flag     <= !fifo_empty;
        underrun                <= fifo_empty;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

endmodule
